// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage types and constants: bus widths, reset PC, bubble encoding, FSM states.
package ifu_fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef logic [ADDR_W-1:0] AddrBus;
    typedef logic [INST_W-1:0] InstBus;

    localparam AddrBus PC_INIT  = 64'h8000_0000;
    localparam InstBus NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    // WAIT: one request in flight whose data is wanted.
    // DROP: one request in flight whose data is stale (a jump overtook it).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetchState_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {addr, inst} holding slot for a response that lands while IF/ID is frozen.
module fetch_skid_buf #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic [INST_W-1:0] pushInst,
    output logic              full,
    output logic [ADDR_W-1:0] headAddr,
    output logic [INST_W-1:0] headInst
);

    // Clear beats push beats pop; push with pop keeps the slot full with the new entry.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            full     <= 1'b0;
            headAddr <= '0;
            headInst <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full     <= 1'b1;
            headAddr <= pushAddr;
            headInst <= pushInst;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC generation, single-outstanding imem requests, stale-response drop,
// and the {addr, inst, valid} register feeding IF/ID with hold/jump handling.
module ifu_fetch #(
    parameter int                ADDR_W   = ifu_fetch_pkg::ADDR_W,
    parameter int                INST_W   = ifu_fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0] PC_INIT  = ifu_fetch_pkg::PC_INIT,
    parameter logic [INST_W-1:0] NOP_INST = ifu_fetch_pkg::NOP_INST
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              JumpFlag,
    input  logic [ADDR_W-1:0] JumpAddr,
    input  logic              HoldFlag,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemReady,
    input  logic              ImemRespValid,
    input  logic [INST_W-1:0] ImemRespData,
    output logic [ADDR_W-1:0] InstAddrOut,
    output logic [INST_W-1:0] InstOut,
    output logic              InstValid
);
    import ifu_fetch_pkg::*;

    fetchState_e       state, stateNext;
    logic [ADDR_W-1:0] pc, reqPc;
    logic              handshake, respFire;
    logic              skidFull, skidPush, skidPop;
    logic [ADDR_W-1:0] skidAddr;
    logic [INST_W-1:0] skidInst;

    // Request only from IDLE with room to park the answer; a jump cycle never issues.
    assign ImemAddr  = pc;
    assign handshake = ImemReq && ImemReady;
    // A response is kept only when it belongs to a live request and no jump kills it now.
    assign respFire  = (state == WAIT) && ImemRespValid && !JumpFlag;

    // Park a response when IF/ID is frozen, or when the skid is draining into it this cycle.
    assign skidPush = respFire && (HoldFlag || skidFull);
    assign skidPop  = !HoldFlag && skidFull;

    fetch_skid_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W)) uSkid (
        .Clk      (Clk),
        .Rst      (Rst),
        .push     (skidPush),
        .pop      (skidPop),
        .clear    (JumpFlag),
        .pushAddr (reqPc),
        .pushInst (ImemRespData),
        .full     (skidFull),
        .headAddr (skidAddr),
        .headInst (skidInst)
    );

    // Fetch state register.
    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state and request decode; a jump in WAIT leaves one response to swallow in DROP.
    always_comb begin
        stateNext = state;
        ImemReq   = 1'b0;
        case (state)
            IDLE: begin
                ImemReq = Rst && !JumpFlag && !skidFull;
                if (ImemReq && ImemReady) stateNext = WAIT;
            end
            WAIT: begin
                if (ImemRespValid)  stateNext = IDLE;
                else if (JumpFlag)  stateNext = DROP;
            end
            DROP: begin
                if (ImemRespValid) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // PC advances on an accepted request; a jump redirects it, misaligned or not.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc    <= PC_INIT;
            reqPc <= PC_INIT;
        end else if (JumpFlag) begin
            pc <= JumpAddr;
        end else if (handshake) begin
            reqPc <= pc;
            pc    <= pc + ADDR_W'(PC_STEP);
        end
    end

    // IF/ID-facing register: jump bubbles, hold freezes, else skid > response > bubble.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            InstAddrOut <= PC_INIT;
            InstOut     <= NOP_INST;
            InstValid   <= 1'b0;
        end else if (JumpFlag) begin
            InstOut   <= NOP_INST;
            InstValid <= 1'b0;
        end else if (!HoldFlag) begin
            if (skidFull) begin
                InstAddrOut <= skidAddr;
                InstOut     <= skidInst;
                InstValid   <= 1'b1;
            end else if (respFire) begin
                InstAddrOut <= reqPc;
                InstOut     <= ImemRespData;
                InstValid   <= 1'b1;
            end else begin
                InstOut   <= NOP_INST;
                InstValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small imem model answering addr^0xFFFF, a scoreboard of
// hand-computed deliveries, and a monitor popping it whenever IF/ID loads a real instruction.
module tb_ifu_fetch;

    localparam logic [63:0] PC_INIT  = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        JumpFlag;
    logic [63:0] JumpAddr;
    logic        HoldFlag;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRespValid = 1'b0;
    logic [31:0] ImemRespData  = '0;
    logic [63:0] InstAddrOut;
    logic [31:0] InstOut;
    logic        InstValid;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
    } expEntry_t;

    expEntry_t   expQ[$];
    int          passCnt  = 0;
    int          totalCnt = 0;
    int          respDelay = 1;
    logic        memPend = 1'b0;
    int          memCnt  = 0;
    logic [63:0] memAddr = '0;
    logic        holdQ   = 1'b0;

    ifu_fetch dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .JumpFlag      (JumpFlag),
        .JumpAddr      (JumpAddr),
        .HoldFlag      (HoldFlag),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemReady     (ImemReady),
        .ImemRespValid (ImemRespValid),
        .ImemRespData  (ImemRespData),
        .InstAddrOut   (InstAddrOut),
        .InstOut       (InstOut),
        .InstValid     (InstValid)
    );

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Memory model: response valid respDelay cycles after acceptance, data = addr ^ 0xFFFF.
    always @(posedge Clk) begin
        if (!Rst) begin
            ImemRespValid <= 1'b0;
            memPend       <= 1'b0;
            memCnt        <= 0;
        end else begin
            ImemRespValid <= 1'b0;
            if (ImemReq && ImemReady) begin
                if (respDelay <= 1) begin
                    ImemRespValid <= 1'b1;
                    ImemRespData  <= ImemAddr[31:0] ^ 32'h0000_FFFF;
                end else begin
                    memPend <= 1'b1;
                    memCnt  <= respDelay - 1;
                    memAddr <= ImemAddr;
                end
            end else if (memPend) begin
                if (memCnt == 1) begin
                    ImemRespValid <= 1'b1;
                    ImemRespData  <= memAddr[31:0] ^ 32'h0000_FFFF;
                    memPend       <= 1'b0;
                end else begin
                    memCnt <= memCnt - 1;
                end
            end
        end
    end

    // Hold as seen at the last edge: a valid output after a non-held edge is a fresh load.
    always @(posedge Clk) holdQ <= HoldFlag;

    // Monitor: every fresh delivery must match the head of the scoreboard.
    initial forever begin
        expEntry_t e;
        @(negedge Clk);
        if (Rst === 1'b1 && InstValid === 1'b1 && holdQ === 1'b0) begin
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpected_delivery: got addr %h inst %h, expected no delivery",
                         InstAddrOut, InstOut);
            end else begin
                e = expQ.pop_front();
                chk("deliv_addr", InstAddrOut, e.addr);
                chk("deliv_inst", {32'h0, InstOut}, {32'h0, e.inst});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    // Directed stimulus; timing comments name the edge just passed.
    initial begin
        Rst = 1'b0; JumpFlag = 1'b0; JumpAddr = '0; HoldFlag = 1'b0; ImemReady = 1'b0;
        repeat (3) step();
        chk("rst_valid", InstValid, 0);
        chk("rst_inst", InstOut, NOP_INST);
        chk("rst_addr", InstAddrOut, PC_INIT);
        chk("rst_req", ImemReq, 0);

        expQ.push_back('{64'h8000_0000, 32'h8000_FFFF});
        expQ.push_back('{64'h8000_0004, 32'h8000_FFFB});
        expQ.push_back('{64'h8000_0008, 32'h8000_FFF7});

        // Memory not ready for 3 cycles: request held, address stable.
        Rst = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", ImemReq, 1);
            chk("stall_addr", ImemAddr, 64'h8000_0000);
            step();
        end
        ImemReady = 1'b1;
        step();                                   // E4: accepted
        chk("wait_req", ImemReq, 0);
        step();                                   // E5: 0x80000000 delivered
        chk("next_addr", ImemAddr, 64'h8000_0004);

        // Hold 4 cycles while 0x80000004 comes back into the skid.
        HoldFlag = 1'b1;
        step();                                   // E6: accepted under hold
        step();                                   // E7: response parked
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", InstValid, 1);
            chk("hold_addr", InstAddrOut, 64'h8000_0000);
            chk("hold_inst", {32'h0, InstOut}, 64'h8000_FFFF);
            chk("hold_req", ImemReq, 0);
            if (i < 2) step();
        end
        HoldFlag = 1'b0;
        step();                                   // E10: skid drained (0x80000004)
        chk("resume_req", ImemReq, 1);
        chk("resume_addr", ImemAddr, 64'h8000_0008);
        step();                                   // E11: accepted
        chk("bubble_valid", InstValid, 0);
        step();                                   // E12: 0x80000008 delivered
        chk("addr_c", ImemAddr, 64'h8000_000C);

        // Jump while WAIT, response 2 cycles later is dropped.
        respDelay = 3;
        step();                                   // E13: 0x8000000C accepted
        chk("waitc_req", ImemReq, 0);
        JumpFlag = 1'b1; JumpAddr = 64'h8000_1000;
        step();                                   // E14: jump -> DROP
        JumpFlag = 1'b0; respDelay = 1;
        chk("jump_valid", InstValid, 0);
        chk("jump_inst", InstOut, NOP_INST);
        chk("jump_addr", InstAddrOut, 64'h8000_0008);
        chk("drop_req", ImemReq, 0);
        step();                                   // E15: stale response on the bus
        chk("drop_req2", ImemReq, 0);
        expQ.push_back('{64'h8000_1000, 32'h8000_EFFF});
        step();                                   // E16: stale response swallowed
        chk("tgt_req", ImemReq, 1);
        chk("tgt_addr", ImemAddr, 64'h8000_1000);
        chk("drop_valid", InstValid, 0);
        step();                                   // E17: accepted
        step();                                   // E18: 0x80001000 delivered

        // Fill the skid under hold, then jump with hold still high.
        HoldFlag = 1'b1;
        step();                                   // E19: 0x80001004 accepted
        step();                                   // E20: parked in skid
        chk("skid_req", ImemReq, 0);
        chk("skid_keep", InstAddrOut, 64'h8000_1000);
        JumpFlag = 1'b1; JumpAddr = 64'h8000_2000;
        step();                                   // E21: jump over hold
        JumpFlag = 1'b0; #1;
        chk("jh_valid", InstValid, 0);
        chk("jh_inst", InstOut, NOP_INST);
        chk("jh_addr", InstAddrOut, 64'h8000_1000);
        chk("jh_req", ImemReq, 1);
        chk("jh_pc", ImemAddr, 64'h8000_2000);
        expQ.push_back('{64'h8000_2000, 32'h8000_DFFF});
        HoldFlag = 1'b0;
        step();                                   // E22: accepted
        step();                                   // E23: 0x80002000 delivered
        step();                                   // E24: 0x80002004 accepted

        // Reset in the middle of WAIT.
        chk("mid_wait_req", ImemReq, 0);
        Rst = 1'b0;
        step();                                   // E25: reset
        chk("rst2_valid", InstValid, 0);
        chk("rst2_inst", InstOut, NOP_INST);
        chk("rst2_addr", InstAddrOut, PC_INIT);
        chk("rst2_req", ImemReq, 0);
        expQ.push_back('{64'h8000_0000, 32'h8000_FFFF});
        Rst = 1'b1; #1;
        chk("rst2_req_rel", ImemReq, 1);
        chk("rst2_addr_rel", ImemAddr, PC_INIT);
        step();                                   // E26: accepted
        ImemReady = 1'b0;
        step();                                   // E27: delivered
        repeat (3) step();
        chk("queue_drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
